// File: rtl/image_mem_sequencer_pkg.sv
// image_mem_sequencer_pkg: run-state encoding, memory-port owner and pipeline depth shared by the sequencer files
package image_mem_sequencer_pkg;
    typedef enum logic [1:0] {LOAD, RUN, DRAIN, DONE} state_t;
    typedef enum logic {OWN_HOST, OWN_CPU} owner_t;
    localparam int PIPE_STAGES = 5;
endpackage

// File: rtl/image_mem_sequencer_mem_port_mux.sv
// mem_port_mux: selects host or MEM-stage we/addr/wdata onto the single memory port according to owner
//   owner                              current port owner
//   host_we/host_addr/host_wdata       granted host access (we already qualified by grant)
//   cpu_we/cpu_addr/cpu_wdata          MEM-stage access, 32-bit address truncated to ADDR_W
//   we/addr/wdata                      memory port
module mem_port_mux
    import image_mem_sequencer_pkg::*;
#(
    parameter int ADDR_W = 16
)(
    input  owner_t            owner,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata
);
    logic unused_addr;
    assign unused_addr = ^cpu_addr;
    assign we = owner == OWN_HOST ? host_we : cpu_we;
    assign addr = owner == OWN_HOST ? host_addr : cpu_addr[ADDR_W-1:0];
    assign wdata = owner == OWN_HOST ? host_wdata : cpu_wdata;
endmodule

// File: rtl/image_mem_sequencer.sv
// image_mem_sequencer: run controller and memory-port arbiter for the filter pipeline's data memory
//   clk, rst                               clock, synchronous active-high reset
//   start                                  begin a run (LOAD/DONE only)
//   host_req/we/addr/wdata, host_gnt       host access, granted same cycle while host owns the port
//   host_rdata/host_rvalid                 read data one cycle after a read grant
//   cpu_we/addr/wdata, cpu_halt            MEM-stage access and halt indication
//   mem_we/addr/wdata, mem_rdata           single synchronous memory port
//   pipe_freeze, pipe_flush                pipeline hold and IF/ID bubble during drain
//   busy, done, timeout, run_cycles        run status
module image_mem_sequencer
    import image_mem_sequencer_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          DRAIN_CYC = 3,
    parameter int unsigned MAX_CYC   = 1000000
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_gnt,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_halt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              pipe_freeze,
    output logic              pipe_flush,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       run_cycles
);
    state_t state;
    owner_t owner;
    logic [7:0] drain_cnt;
    logic host_owns, rvalid, mux_we;
    assign host_owns = state == LOAD || state == DONE;
    assign owner = host_owns ? OWN_HOST : OWN_CPU;
    // no grant and no write in a reset cycle, whatever state we are leaving
    assign host_gnt = !rst && host_owns && host_req;
    assign mem_we = !rst && mux_we;
    assign host_rvalid = rvalid;
    assign host_rdata = rvalid ? mem_rdata : 8'h00;
    assign pipe_freeze = host_owns;
    assign pipe_flush = state == DRAIN;
    assign busy = !host_owns;
    assign done = state == DONE;
    mem_port_mux #(.ADDR_W(ADDR_W)) u_mux (
        .owner(owner),
        .host_we(host_gnt && host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .we(mux_we),
        .addr(mem_addr),
        .wdata(mem_wdata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            drain_cnt <= 8'd0;
            run_cycles <= 32'd0;
            timeout <= 1'b0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= host_gnt && !host_we;
            if (busy && run_cycles != 32'hFFFF_FFFF)
                run_cycles <= run_cycles + 32'd1;
            case (state)
                LOAD, DONE: if (start) begin
                    state <= RUN;
                    run_cycles <= 32'd0;
                    timeout <= 1'b0;
                end
                RUN: if (MAX_CYC != 0 && run_cycles == 32'(MAX_CYC - 1)) begin
                    state <= DONE;
                    timeout <= 1'b1;
                end else if (cpu_halt) begin
                    state <= DRAIN;
                    drain_cnt <= 8'(DRAIN_CYC);
                end
                // leave on the cycle the counter reaches zero, so DRAIN lasts DRAIN_CYC cycles
                DRAIN: begin
                    drain_cnt <= drain_cnt - 8'd1;
                    if (drain_cnt <= 8'd1)
                        state <= DONE;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_image_mem_sequencer.sv
// tb_image_mem_sequencer: randomized scoreboard bench with a byte-array memory model for image_mem_sequencer
module tb_image_mem_sequencer;
    localparam int ADDR_W = 16;
    localparam int DRAIN_CYC = 3;
    localparam int MAX_CYC = 16;
    logic clk = 1'b0;
    logic rst, start, host_req, host_we, host_gnt, host_rvalid;
    logic [15:0] host_addr, mem_addr;
    logic [7:0] host_wdata, host_rdata, cpu_wdata, mem_wdata, mem_rdata;
    logic cpu_we, cpu_halt, mem_we, pipe_freeze, pipe_flush, busy, done, timeout;
    logic [31:0] cpu_addr, run_cycles;
    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] exp_q [$];
    int compared = 0;
    int mismatched = 0;

    image_mem_sequencer #(.ADDR_W(ADDR_W), .DRAIN_CYC(DRAIN_CYC), .MAX_CYC(MAX_CYC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_halt(cpu_halt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pipe_freeze(pipe_freeze), .pipe_flush(pipe_flush), .busy(busy), .done(done),
        .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (host_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rvalid_unexpected: got pulse with data %0h expected no pulse at %0t", host_rdata, $time);
            end else begin
                check("host_rdata", host_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        host_req = 1'b0;
        host_we = 1'b0;
        host_addr = 16'($urandom);
        host_wdata = 8'($urandom);
        cpu_we = 1'($urandom);
        cpu_addr = $urandom;
        cpu_wdata = 8'($urandom);
        cpu_halt = 1'($urandom);
    endtask

    task automatic host_op(input logic we, input logic [15:0] addr, input logic [7:0] data, input logic with_start);
        step();
        host_req = 1'b1;
        host_we = we;
        host_addr = addr;
        host_wdata = data;
        start = with_start;
        @(negedge clk);
        check("host_gnt", host_gnt, 1);
        check("mem_we_host", mem_we, we);
        if (we)
            ref_mem[addr] = data;
        else
            exp_q.push_back(ref_mem[addr]);
    endtask

    task automatic run_prog(input int halt_at, input bit hold_req, input bit rd_with_start, input int rst_at,
                            input bit store_3c);
        int total;
        bit tout, in_drain;
        logic [15:0] hold_addr;
        hold_addr = 16'($urandom_range(0, 127));
        tout = halt_at >= MAX_CYC - 1;
        total = tout ? MAX_CYC : halt_at + 1 + DRAIN_CYC;
        if (rd_with_start)
            host_op(1'b0, 16'($urandom_range(0, 127)), 8'h00, 1'b1);
        else begin
            step();
            start = 1'b1;
        end
        for (int c = 0; c < total; c++) begin
            step();
            in_drain = !tout && c > halt_at;
            cpu_addr = {16'($urandom), 16'(64 + $urandom_range(0, 63))};
            cpu_halt = c == halt_at || (in_drain && 1'($urandom));
            start = $urandom_range(0, 3) == 0;
            if (store_3c) begin
                cpu_we = c == 0;
                cpu_addr = 32'h0000_0020;
                cpu_wdata = 8'h3C;
            end
            if (hold_req) begin
                host_req = 1'b1;
                host_we = 1'b0;
                host_addr = hold_addr;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                cpu_we = 1'b1;
                cpu_addr = 32'h0000_0F00;
                cpu_wdata = 8'h77;
                @(negedge clk);
                check("rst_no_write", mem_we, 0);
                check("rst_no_gnt", host_gnt, 0);
                step();
                rst = 1'b0;
                @(negedge clk);
                check("rst_freeze", pipe_freeze, 1);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_flush", pipe_flush, 0);
                check("rst_run_cycles", run_cycles, 0);
                return;
            end
            @(negedge clk);
            check("run_busy", busy, 1);
            check("run_freeze", pipe_freeze, 0);
            check("run_flush", pipe_flush, in_drain);
            check("run_done", done, 0);
            check("run_gnt", host_gnt, 0);
            check("run_mem_we", mem_we, cpu_we);
            check("run_mem_addr", mem_addr, cpu_addr[15:0]);
            if (cpu_we)
                ref_mem[cpu_addr[15:0]] = cpu_wdata;
        end
        step();
        if (hold_req) begin
            host_req = 1'b1;
            host_we = 1'b0;
            host_addr = hold_addr;
        end
        @(negedge clk);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_freeze", pipe_freeze, 1);
        check("end_flush", pipe_flush, 0);
        check("end_timeout", timeout, tout);
        check("end_run_cycles", run_cycles, total);
        if (hold_req) begin
            check("gnt_at_done", host_gnt, 1);
            exp_q.push_back(ref_mem[hold_addr]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL bench_timeout: simulation did not finish expected to finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst = 1'b1;
        start = 1'b0;
        host_req = 1'b0;
        host_we = 1'b0;
        host_addr = 16'h0;
        host_wdata = 8'h0;
        cpu_we = 1'b1;
        cpu_addr = 32'h0;
        cpu_wdata = 8'h0;
        cpu_halt = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("reset_mem_we", mem_we, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_freeze", pipe_freeze, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_flush", pipe_flush, 0);
        check("reset_timeout", timeout, 0);
        check("reset_run_cycles", run_cycles, 0);
        check("reset_rvalid", host_rvalid, 0);
        check("reset_gnt_idle", host_gnt, 0);
        // host write then read back
        host_op(1'b1, 16'h0010, 8'hA5, 1'b0);
        host_op(1'b0, 16'h0010, 8'h00, 1'b0);
        // store in first RUN cycle, halt in fifth RUN cycle
        run_prog(4, 1'b0, 1'b0, -1, 1'b1);
        host_op(1'b0, 16'h0020, 8'h00, 1'b0);
        // host request held through a run
        run_prog(6, 1'b1, 1'b0, -1, 1'b0);
        // watchdog
        run_prog(99, 1'b0, 1'b0, -1, 1'b0);
        // reset during drain with a host read waiting
        run_prog(5, 1'b1, 1'b0, 7, 1'b0);
        host_op(1'b0, 16'h0F00, 8'h00, 1'b0);
        // read and start in the same cycle
        run_prog(2, 1'b0, 1'b1, -1, 1'b0);
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < int'($urandom_range(2, 6)); k++)
                host_op(1'($urandom), 16'($urandom_range(0, 127)), 8'($urandom), 1'b0);
            run_prog($urandom_range(0, 4) == 0 ? 99 : int'($urandom_range(0, 12)),
                     1'($urandom), 1'($urandom), -1, 1'b0);
        end
        for (int k = 0; k < 64; k++)
            host_op(1'b0, 16'(64 + k), 8'h00, 1'b0);
        step();
        step();
        step();
        check("rvalid_outstanding", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
